// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus decoder: FSM encoding, wait-counter
// width and the region-index width helper.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int WAIT_W = 4;

  // A single region still needs a one-bit index so that every port stays sized.
  function automatic int idx_width(input int num_reg);
    return (num_reg > 1) ? $clog2(num_reg) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_decoder_if.sv
// CPU load/store handshake between the CPU state machine (master) and the
// MMIO decoder (slave).
interface mmio_bus_decoder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic              rdy;
  logic [DATA_W-1:0] rdata;
  logic              fault;

  modport master (
    output req, we, adr, wdata,
    input  rdy, rdata, fault
  );

  modport slave (
    input  req, we, adr, wdata,
    output rdy, rdata, fault
  );

endinterface

// File: rtl/mmio_region_match.sv
// Combinational priority range compare: finds the lowest-index region whose
// inclusive [base, limit] window contains adr, and flags writes to protected regions.
module mmio_region_match
  import mmio_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NUM_REG = 4,
  parameter int IDX_W   = idx_width(NUM_REG)
) (
  input  logic [ADDR_W-1:0]         adr,
  input  logic [NUM_REG*ADDR_W-1:0] base,
  input  logic [NUM_REG*ADDR_W-1:0] limit,
  input  logic [NUM_REG-1:0]        ro,
  input  logic                      we,
  output logic                      hit,
  output logic [IDX_W-1:0]          index,
  output logic                      ro_violation
);

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    // Scanning from the top down lets the lowest matching index overwrite the rest.
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      if ((adr >= base[i*ADDR_W +: ADDR_W]) && (adr <= limit[i*ADDR_W +: ADDR_W])) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
    ro_violation = hit && we && ro[index];
  end

endmodule

// File: rtl/mmio_bus_decoder.sv
// Registered memory-map decoder and access sequencer between the CPU load/store
// port and the memory/peripheral devices, with wait states, write protection and fault capture.
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int                          ADDR_W       = 16,
  parameter int                          DATA_W       = 16,
  parameter int                          NUM_REG      = 4,
  parameter logic [NUM_REG*ADDR_W-1:0]   REGION_BASE  = {16'hC100, 16'hC000, 16'hA000, 16'h0000},
  parameter logic [NUM_REG*ADDR_W-1:0]   REGION_LIMIT = {16'hC1FF, 16'hC0FF, 16'hBFFF, 16'h9FFF},
  parameter logic [NUM_REG*WAIT_W-1:0]   REGION_WAIT  = {4'd3, 4'd2, 4'd0, 4'd0},
  parameter logic [NUM_REG-1:0]          REGION_RO    = 4'b0001
) (
  input  logic                      clk,
  input  logic                      rst,
  mmio_bus_decoder_if.slave         cpu,
  output logic [NUM_REG-1:0]        sel,
  output logic [ADDR_W-1:0]         dev_adr,
  output logic                      dev_we,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [NUM_REG*DATA_W-1:0] dev_rdata,
  output logic [ADDR_W-1:0]         fault_adr,
  output logic [7:0]                fault_cnt
);

  localparam int IDX_W = idx_width(NUM_REG);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;
  localparam logic [1:0] S_FAULT  = FAULT;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wcnt;
  logic [IDX_W-1:0]  idx;
  logic              wr;
  logic [DATA_W-1:0] rdata_q;

  logic              hit;
  logic              ro_violation;
  logic [IDX_W-1:0]  hit_idx;
  logic              access_done;

  mmio_region_match #(
    .ADDR_W  (ADDR_W),
    .NUM_REG (NUM_REG),
    .IDX_W   (IDX_W)
  ) u_match (
    .adr          (cpu.adr),
    .base         (REGION_BASE),
    .limit        (REGION_LIMIT),
    .ro           (REGION_RO),
    .we           (cpu.we),
    .hit          (hit),
    .index        (hit_idx),
    .ro_violation (ro_violation)
  );

  assign access_done = (state == S_ACCESS) && (wcnt == '0);
  assign dev_we      = access_done && wr;

  assign cpu.rdy   = (state == S_RESP) || (state == S_FAULT);
  assign cpu.fault = (state == S_FAULT);
  assign cpu.rdata = rdata_q;

  always_comb begin
    sel = '0;
    if (state == S_ACCESS) begin
      for (int i = 0; i < NUM_REG; i++) begin
        sel[i] = (idx == IDX_W'(i));
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      idx       <= '0;
      wr        <= 1'b0;
      rdata_q   <= '0;
      dev_adr   <= '0;
      dev_wdata <= '0;
      fault_adr <= '0;
      fault_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu.req) begin
            if (!hit || ro_violation) begin
              // Fault bookkeeping lands on entry so it is visible alongside the fault pulse.
              state     <= S_FAULT;
              rdata_q   <= '0;
              fault_adr <= cpu.adr;
              if (fault_cnt != 8'hFF) begin
                fault_cnt <= fault_cnt + 8'd1;
              end
            end else begin
              state     <= S_ACCESS;
              idx       <= hit_idx;
              wr        <= cpu.we;
              dev_adr   <= cpu.adr - REGION_BASE[hit_idx*ADDR_W +: ADDR_W];
              dev_wdata <= cpu.wdata;
              wcnt      <= REGION_WAIT[hit_idx*WAIT_W +: WAIT_W];
            end
          end
        end
        S_ACCESS: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WAIT_W'(1);
          end else begin
            if (!wr) begin
              rdata_q <= dev_rdata[idx*DATA_W +: DATA_W];
            end
            state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Scoreboard bench for mmio_bus_decoder: the driver queues expected responses and
// write strobes, a negedge monitor pops and compares them as the DUT produces them.
module tb_mmio_bus_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [15:0] dev_adr;
  logic        dev_we;
  logic [15:0] dev_wdata;
  logic [63:0] dev_rdata;
  logic [15:0] fault_adr;
  logic [7:0]  fault_cnt;

  always #5 clk = ~clk;

  mmio_bus_decoder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  assign dev_rdata = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'h1234};

  mmio_bus_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .sel       (sel),
    .dev_adr   (dev_adr),
    .dev_we    (dev_we),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .fault_adr (fault_adr),
    .fault_cnt (fault_cnt)
  );

  typedef struct {
    logic [15:0] rdata;
    bit          chk_rdata;
    logic        fault;
    logic [15:0] fadr;
    logic [7:0]  fcnt;
    int          cyc;
    logic [3:0]  sel;
    int          sel_cycles;
    logic [15:0] dadr;
  } rsp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] dadr;
    logic [15:0] wdata;
    int          cyc;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] base_tab  [4] = '{16'h0000, 16'hA000, 16'hC000, 16'hC100};
  logic [15:0] slice_tab [4] = '{16'h1234, 16'hB1B1, 16'hC2C2, 16'hD3D3};
  int          wait_tab  [4] = '{0, 0, 2, 3};

  logic [15:0] exp_fadr = 16'h0000;
  logic [7:0]  exp_fcnt = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after the
  // response cycle, where the DUT is back in IDLE.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input int region, input bit hold, input bit scramble);
    rsp_t e;
    wr_t  x;
    bit   flt;
    bit   got;
    int   lat;
    flt = (region < 0) || (w && region == 0);
    e.fault      = flt;
    e.chk_rdata  = flt || !w;
    if (flt) begin
      lat = 1;
      exp_fadr = a;
      if (exp_fcnt != 8'hFF) exp_fcnt++;
      e.sel        = 4'b0000;
      e.sel_cycles = 0;
      e.dadr       = 16'h0000;
      e.rdata      = 16'h0000;
    end else begin
      lat = wait_tab[region] + 2;
      e.sel        = 4'(1 << region);
      e.sel_cycles = wait_tab[region] + 1;
      e.dadr       = a - base_tab[region];
      e.rdata      = slice_tab[region];
    end
    e.fadr = exp_fadr;
    e.fcnt = exp_fcnt;
    e.cyc  = cyc + lat;
    rq.push_back(e);
    if (!flt && w) begin
      x.sel   = e.sel;
      x.dadr  = e.dadr;
      x.wdata = d;
      x.cyc   = cyc + lat - 1;
      wq.push_back(x);
    end
    bus.req   = 1'b1;
    bus.we    = w;
    bus.adr   = a;
    bus.wdata = d;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rdy) begin
        got = 1'b1;
        break;
      end
      if (scramble) begin
        bus.adr   = 16'hFFFF;
        bus.wdata = 16'hDEAD;
        bus.we    = ~w;
      end
    end
    check("rdy_within_budget", 32'(got), 32'd1);
    if (!hold) bus.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [3:0]  sel_or;
    int          sel_n;
    logic [15:0] seen_adr;
    rsp_t        e;
    wr_t         x;
    sel_or   = 4'b0000;
    sel_n    = 0;
    seen_adr = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        sel_or = 4'b0000;
        sel_n  = 0;
      end else begin
        if (sel != 4'b0000) begin
          sel_or   = sel_or | sel;
          sel_n++;
          seen_adr = dev_adr;
        end
        if (dev_we) begin
          check("dev_we_expected", 32'(wq.size() > 0), 32'd1);
          if (wq.size() > 0) begin
            x = wq.pop_front();
            check("we_sel",   32'(sel),       32'(x.sel));
            check("we_adr",   32'(dev_adr),   32'(x.dadr));
            check("we_wdata", 32'(dev_wdata), 32'(x.wdata));
            check("we_cycle", 32'(cyc),       32'(x.cyc));
          end
        end
        if (bus.rdy) begin
          check("rdy_expected", 32'(rq.size() > 0), 32'd1);
          if (rq.size() > 0) begin
            e = rq.pop_front();
            check("rsp_fault",     32'(bus.fault), 32'(e.fault));
            check("rsp_fault_adr", 32'(fault_adr), 32'(e.fadr));
            check("rsp_fault_cnt", 32'(fault_cnt), 32'(e.fcnt));
            check("rsp_latency",   32'(cyc),       32'(e.cyc));
            check("rsp_sel",       32'(sel_or),    32'(e.sel));
            check("rsp_sel_cycles", 32'(sel_n),    32'(e.sel_cycles));
            if (e.chk_rdata) check("rsp_rdata", 32'(bus.rdata), 32'(e.rdata));
            if (!e.fault) check("rsp_dev_adr", 32'(seen_adr), 32'(e.dadr));
          end
          sel_or = 4'b0000;
          sel_n  = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst       = 1'b1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.adr   = 16'h0000;
    bus.wdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_state",     32'(dut.state), 32'd0);
    check("reset_rdy",       32'(bus.rdy),   32'd0);
    check("reset_fault",     32'(bus.fault), 32'd0);
    check("reset_sel",       32'(sel),       32'd0);
    check("reset_dev_we",    32'(dev_we),    32'd0);
    check("reset_rdata",     32'(bus.rdata), 32'd0);
    check("reset_dev_adr",   32'(dev_adr),   32'd0);
    check("reset_dev_wdata", 32'(dev_wdata), 32'd0);
    check("reset_fault_adr", 32'(fault_adr), 32'd0);
    check("reset_fault_cnt", 32'(fault_cnt), 32'd0);
    rst = 1'b0;

    do_access(1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0);
    do_access(1'b1, 16'hC005, 16'h00AA, 2, 1'b0, 1'b1);
    do_access(1'b1, 16'h0020, 16'h1111, 0, 1'b0, 1'b0);

    do_access(1'b0, 16'h9FFF, 16'h0000, 0, 1'b1, 1'b0);
    do_access(1'b0, 16'hA000, 16'h0000, 1, 1'b1, 1'b0);
    do_access(1'b0, 16'hC0FF, 16'h0000, 2, 1'b1, 1'b0);
    do_access(1'b0, 16'hC100, 16'h0000, 3, 1'b1, 1'b0);
    do_access(1'b0, 16'hC1FF, 16'h0000, 3, 1'b0, 1'b0);
    do_access(1'b1, 16'hB000, 16'hBEEF, 1, 1'b0, 1'b0);
    do_access(1'b0, 16'hC200, 16'h0000, -1, 1'b0, 1'b0);
    do_access(1'b1, 16'hFFFF, 16'h7777, -1, 1'b0, 1'b0);

    for (int i = 0; i < 260; i++) begin
      do_access(1'b0, 16'hD000, 16'h0000, -1, (i != 259), 1'b0);
    end
    check("fault_cnt_saturated", 32'(fault_cnt), 32'h0000_00FF);

    // Abort a region-3 write mid-access with reset.
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.adr   = 16'hC105;
    bus.wdata = 16'h5555;
    @(negedge clk);
    check("abort_sel_before", 32'(sel), 32'h8);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sel",   32'(sel),       32'd0);
    check("abort_state", 32'(dut.state), 32'd0);
    check("abort_rdy",   32'(bus.rdy),   32'd0);
    rst      = 1'b0;
    bus.req  = 1'b0;
    exp_fcnt = 8'h00;
    exp_fadr = 16'h0000;
    @(negedge clk);
    check("abort_fault_cnt", 32'(fault_cnt), 32'd0);

    do_access(1'b0, 16'hC100, 16'h0000, 3, 1'b0, 1'b0);
    do_access(1'b0, 16'hD000, 16'h0000, -1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("responses_drained", 32'(rq.size()), 32'd0);
    check("writes_drained",    32'(wq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_bus_decoder.md
Name: mmio_bus_decoder

Overview:
- Parametrised memory-map decoder and access sequencer between the 16-bit CPU load/store port and its memory and peripheral devices.
- Replaces the fixed, combinational program/data/I-O enable split with a registered, handshaked transaction engine.
- Supports NUM_REG configurable address regions, per-region wait states, per-region read-only protection, and fault capture.
- Sits between the CPU state machine and the memory, VGA, controller and random-value devices.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- NUM_REG, 4, number of decoded regions (1..8).
- REGION_BASE, {16'hC100,16'hC000,16'hA000,16'h0000}, packed NUM_REG*ADDR_W; inclusive lower bound per region; region 0 in the LSBs.
- REGION_LIMIT, {16'hC1FF,16'hC0FF,16'hBFFF,16'h9FFF}, packed NUM_REG*ADDR_W; inclusive upper bound per region.
- REGION_WAIT, {4'd3,4'd2,4'd0,4'd0}, packed NUM_REG*4; extra wait cycles per region.
- REGION_RO, 4'b0001, per-region write-protect mask; bit i set means writes to region i fault.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  CPU access request; held high until rdy.
- we  in  1  1 = write, 0 = read; sampled with req.
- adr  in  ADDR_W  CPU byte-free word address.
- wdata  in  DATA_W  write data.
- rdy  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while rdy is high.
- fault  out  1  one-cycle pulse coincident with rdy when the access is rejected.
- sel  out  NUM_REG  one-hot device select, high only during ACCESS.
- dev_adr  out  ADDR_W  address offset, adr minus the matched region's base.
- dev_we  out  1  single-cycle write strobe to the selected device.
- dev_wdata  out  DATA_W  registered write data.
- dev_rdata  in  NUM_REG*DATA_W  packed read data, one slice per region.
- fault_adr  out  ADDR_W  address of the most recent fault.
- fault_cnt  out  8  saturating fault counter.

Behaviour:
- Reset values:
  - state = IDLE.
  - rdy, fault, dev_we = 0; sel = 0.
  - rdata, dev_adr, dev_wdata, fault_adr = 0; fault_cnt = 0.
  - Reset applied mid-transaction aborts the transaction: sel drops on the next edge and no write strobe is issued.
- Decode (combinational, in IDLE):
  - Region i matches when BASE_i <= adr <= LIMIT_i, unsigned compare.
  - Overlapping regions: the lowest index wins.
  - A fault is raised when no region matches, or when we=1 and REGION_RO[i] is set.
- FSM:
  - IDLE: on req=1, latch adr-offset, we, wdata and the region index.
    - Fault case: go to FAULT.
    - Otherwise: load wcnt = REGION_WAIT[i] and go to ACCESS.
  - ACCESS: sel[i]=1 and dev_adr is stable.
    - While wcnt != 0, decrement wcnt and stay.
    - When wcnt == 0: pulse dev_we if we=1; on a read, capture dev_rdata slice i into rdata; go to RESP.
  - RESP: rdy=1 for one cycle, sel=0, then go to IDLE.
  - FAULT: rdy=1 and fault=1 for one cycle, rdata=0, fault_adr = the full adr, fault_cnt increments and saturates at 255; then go to IDLE.
- Latency from the req-sampling edge to rdy high:
  - Good access: WAIT+2 cycles.
  - Fault: 1 cycle.
- Handshake:
  - req is ignored outside IDLE.
  - A req still high in the cycle after rdy is accepted as a new transaction; back-to-back throughput is one access per WAIT+3 cycles.
- Changes to we, adr or wdata after acceptance have no effect on the transaction in flight.
- Boundaries:
  - adr == BASE and adr == LIMIT both match.
  - With LIMIT = 16'hFFFF, the compare must not wrap.
  - Counter saturation holds at 8'hFF.

Decomposition:
- Package mmio_pkg holds:
  - the state enum {IDLE, ACCESS, RESP, FAULT};
  - the WAIT_W=4 constant;
  - the region-index width, clog2(NUM_REG).
- One natural sub-module: mmio_region_match, a purely combinational priority range compare.
  - Inputs: adr, BASE, LIMIT, RO, we.
  - Outputs: hit, index, ro_violation.

Test Plan:
- Read adr=16'h0010 (region 0, wait 0), dev_rdata slice0=16'h1234 -> sel=4'b0001 for one cycle, rdy with rdata=16'h1234 two cycles after acceptance, fault=0.
- Write adr=16'hC005, wdata=16'h00AA (region 2, wait 2) -> sel=4'b0100 for 3 cycles, dev_adr=16'h0005, exactly one dev_we pulse in the last ACCESS cycle, rdy 4 cycles after acceptance.
- Write adr=16'h0020 (read-only region 0) -> FAULT next cycle: rdy=1, fault=1, no dev_we ever, fault_adr=16'h0020, fault_cnt=1.
- Read adr=16'hD000 (unmapped) repeated 260 times -> each access faults, fault_cnt stops at 8'hFF.
- Boundary reads at 16'h9FFF, 16'hA000, 16'hC0FF, 16'hC100 -> select regions 0, 1, 2, 3 respectively.
- rst=1 during ACCESS of a region-3 write -> next edge: sel=0, state=IDLE, rdy=0, no dev_we pulse; a subsequent req is accepted normally.
